param_core: RTL and testbench
=============================

# param_core

Parametrised conditional-execution processing core, successor to the fixed four-register core. It adds configurable register count and data width, a valid/ready instruction handshake, and a req/ack external memory port, so the core no longer owns a RAM. It also has a counted double-buffer swap for the display path. The core sits between the instruction sequencer and the shared memory/frame-buffer arbiter.

## Interface
- DATA_WIDTH, 16: register/ALU/memory data width; must be ≥16.
- ADDRESS_WIDTH, 16: memory address width; addresses are taken from the low ADDRESS_WIDTH bits of a register.
- NUM_REGS, 8: general registers, 2..16.
- FRAME_COUNT_WIDTH, 8: width of the swap counter.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- instr  in  32  instruction word: [3:0] op, [7:4] cond, [11:8] rd, [15:12] ra, [19:16] rb, [27:20] imm8, [31:28] reserved (ignored).
- instr_valid  in  1  instr is presented.
- instr_ready  out  1  core accepts instr this cycle.
- mem_req  out  1  memory request pending.
- mem_we  out  1  request is a store.
- mem_addr  out  ADDRESS_WIDTH  request address.
- mem_wdata  out  DATA_WIDTH  store data.
- mem_rdata  in  DATA_WIDTH  load data, valid with mem_ack.
- mem_ack  in  1  completes the pending request.
- flags  out  4  {Z,V,S,C} = [3:0] order {3:Z, 2:V, 1:S, 0:C}.
- buf_sel  out  1  front frame-buffer select.
- frame_count  out  FRAME_COUNT_WIDTH  swaps since reset, wraps.
- retired  out  1  one-cycle pulse per retired instruction.

## Operation
- States: IDLE (instr_ready=1), MEM (instr_ready=0, mem_req=1). Accept = instr_valid & instr_ready at a rising edge.
- Condition, from flags before the instruction: 0 EQ Z; 1 NE !Z; 2 GT !Z&(S==V); 3 LT S!=V; 4 GE S==V; 5 LE Z|(S!=V); 6 CS C; 7 CC !C; 8 MI S; 9 PL !S; 10 AL; 11 NV; 12 VS V; 13 VC !V; 14 HI C&!Z; 15 LS !C|Z.
- A failed condition retires with no register, flag, memory or buffer effect, and stays in IDLE.
- Ops: 0 ADD, 1 ADC (+C), 2 SUB, 3 SBC (−!C), 4 AND, 5 OR, 6 XOR, 7 SHL, 8 SHR (logical), 9 CMP (SUB, no writeback), 10 MOV rd←ra, 11 MOVL rd[7:0]←imm8, 12 MOVH rd[15:8]←imm8, 13 LD rd←mem[ra], 14 ST mem[ra]←rd, 15 SYS (imm8=0: rd←flags zero-extended; imm8=1: buffer swap; other values: no-op).
- Flags are written only by ops 0–9 when the condition passes. Z = result==0. S = result MSB.
- ADD/ADC: C = carry out, V = signed overflow. SUB/SBC/CMP: C = NOT borrow, so CS after CMP means ra≥rb unsigned; V = signed overflow.
- Logic ops: C=0, V=0.
- Shifts: amount = rb low clog2(DATA_WIDTH) bits. C = last bit shifted out. Amount 0 gives result=ra and C=0. V=0.
- Register index ≥ NUM_REGS: reads return 0, writes are discarded. LD/ST with such an index still performs the access.
- Swap: toggles buf_sel and increments frame_count, wrapping to 0.

## Timing
- Reset: all registers, flags, buf_sel, frame_count, mem_req, mem_we, mem_addr, mem_wdata and retired are 0. State goes to IDLE, so instr_ready=1 in the first cycle after reset deasserts.
- Non-memory ops take effect at the accept edge and retired pulses the following cycle. Back-to-back throughput is 1 instruction/cycle, and a dependent instruction sees the previous result.
- LD/ST with condition passing: at the accept edge, mem_req=1 and mem_addr/mem_we/mem_wdata are loaded; these stay stable until ack.
- At the first edge with mem_ack=1 in MEM: LD writes rd←mem_rdata, mem_req drops, retired pulses next cycle, and state returns to IDLE. Minimum occupancy is 2 cycles.
- mem_ack while in IDLE is ignored. instr_valid while in MEM is not accepted.
- Reset in MEM abandons the request: mem_req=0 after the edge and the load is not written.

## Configuration
- CORE_BUFFER_SWAP_EN defined: SYS imm8=1 performs the swap.
- Not defined: SYS imm8=1 is a retiring no-op, buf_sel is tied to 0, and frame_count is tied to 0.

## Test plan
- Reset → instr_ready=1, flags=0, buf_sel=0; every SYS imm8=0 read of r0..r7 returns 0.
- MOVH r1,0x7F; MOVL r1,0xFF; MOVL r2,0x01; MOVH r2,0x00; ADD r3,r1,r2 → r3=0x8000, flags S=1, V=1, C=0, Z=0.
- CMP r2,r2 then ADD.NE r4,r2,r2 → Z=1, C=1, r4 unchanged (0), retired still pulses.
- ST r3→[r2], ack delayed 3 cycles → mem_req high 3 cycles with addr=0x0001 and wdata=0x8000, instr_ready=0 throughout. Then LD r5←[r2] with rdata=0x1234 → r5=0x1234.
- Reset asserted during a pending LD → mem_req=0 the next cycle and rd=0.
- With CORE_BUFFER_SWAP_EN, 256 SYS imm8=1 (FRAME_COUNT_WIDTH=8) → buf_sel=0, frame_count=0. Without the macro → both stay 0.

Source files
------------

// File: rtl/param_core.sv
// Parametrised conditional-execution core: register file, flag ALU, valid/ready
// instruction intake and req/ack memory port. CORE_BUFFER_SWAP_EN enables the SYS buffer swap.
`timescale 1ns/1ps
module param_core #(
  parameter int DATA_WIDTH        = 16,
  parameter int ADDRESS_WIDTH     = 16,
  parameter int NUM_REGS          = 8,
  parameter int FRAME_COUNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  instr,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDRESS_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  input  logic                         mem_ack,
  output logic [3:0]                   flags,
  output logic                         buf_sel,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
  output logic                         retired
);
  localparam int SHW = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0, OP_ADC = 4'd1, OP_SUB = 4'd2, OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4, OP_OR = 4'd5, OP_XOR = 4'd6, OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8, OP_CMP = 4'd9, OP_MOV = 4'd10, OP_MOVL = 4'd11;
  localparam logic [3:0] OP_MOVH = 4'd12, OP_LD = 4'd13, OP_ST = 4'd14, OP_SYS = 4'd15;

  typedef enum logic {IDLE, MEM} state_t;
  state_t state, state_next;

  logic [3:0] op, cond, rd, ra, rb;
  logic [7:0] imm8;
  logic       unused_bits;
  assign op          = instr[3:0];
  assign cond        = instr[7:4];
  assign rd          = instr[11:8];
  assign ra          = instr[15:12];
  assign rb          = instr[19:16];
  assign imm8        = instr[27:20];
  assign unused_bits = ^instr[31:28];

  logic [DATA_WIDTH-1:0] regs [16];
  logic [DATA_WIDTH-1:0] ra_val, rb_val, rd_val;
  logic [3:0]            ld_rd;

  // Indices at or beyond NUM_REGS read as zero.
  assign ra_val = (int'(ra) < NUM_REGS) ? regs[ra] : '0;
  assign rb_val = (int'(rb) < NUM_REGS) ? regs[rb] : '0;
  assign rd_val = (int'(rd) < NUM_REGS) ? regs[rd] : '0;

  function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
    logic z, v, s, cy, r;
    z = f[3]; v = f[2]; s = f[1]; cy = f[0];
    case (c)
      4'd0:    r = z;
      4'd1:    r = !z;
      4'd2:    r = !z && (s == v);
      4'd3:    r = (s != v);
      4'd4:    r = (s == v);
      4'd5:    r = z || (s != v);
      4'd6:    r = cy;
      4'd7:    r = !cy;
      4'd8:    r = s;
      4'd9:    r = !s;
      4'd10:   r = 1'b1;
      4'd11:   r = 1'b0;
      4'd12:   r = v;
      4'd13:   r = !v;
      4'd14:   r = cy && !z;
      default: r = !cy || z;
    endcase
    return r;
  endfunction

  // Two's-complement overflow from operand and result sign bits.
  function automatic logic add_ovf(input logic a_s, input logic b_s, input logic r_s);
    return (a_s == b_s) && (r_s != a_s);
  endfunction

  function automatic logic sub_ovf(input logic a_s, input logic b_s, input logic r_s);
    return (a_s != b_s) && (r_s != a_s);
  endfunction

  logic cond_pass, accept, exec, is_mem;
  assign cond_pass = cond_check(cond, flags);
  assign accept    = instr_valid && instr_ready;
  assign exec      = accept && cond_pass;
  assign is_mem    = (op == OP_LD) || (op == OP_ST);

  logic                  add_cin, sub_bin;
  logic [SHW-1:0]        shamt;
  logic [DATA_WIDTH:0]   sum_ext, dif_ext, shl_ext, shr_ext;
  logic [DATA_WIDTH-1:0] alu_res, wr_val;
  logic                  alu_c, alu_v, flag_en, wr_en;
  logic [3:0]            alu_flags;

  assign add_cin = (op == OP_ADC) && flags[0];
  assign sub_bin = (op == OP_SBC) && !flags[0];
  assign shamt   = rb_val[SHW-1:0];
  assign sum_ext = {1'b0, ra_val} + {1'b0, rb_val} + {{DATA_WIDTH{1'b0}}, add_cin};
  assign dif_ext = {1'b0, ra_val} - {1'b0, rb_val} - {{DATA_WIDTH{1'b0}}, sub_bin};
  assign shl_ext = {1'b0, ra_val} << shamt;
  assign shr_ext = {ra_val, 1'b0} >> shamt;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    flag_en = (op <= OP_CMP);
    wr_en   = 1'b0;
    wr_val  = '0;
    case (op)
      OP_ADD, OP_ADC: begin
        alu_res = sum_ext[DATA_WIDTH-1:0];
        alu_c   = sum_ext[DATA_WIDTH];
        alu_v   = add_ovf(ra_val[DATA_WIDTH-1], rb_val[DATA_WIDTH-1], alu_res[DATA_WIDTH-1]);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        alu_res = dif_ext[DATA_WIDTH-1:0];
        alu_c   = !dif_ext[DATA_WIDTH];
        alu_v   = sub_ovf(ra_val[DATA_WIDTH-1], rb_val[DATA_WIDTH-1], alu_res[DATA_WIDTH-1]);
      end
      OP_AND: alu_res = ra_val & rb_val;
      OP_OR:  alu_res = ra_val | rb_val;
      OP_XOR: alu_res = ra_val ^ rb_val;
      OP_SHL: begin
        alu_res = shl_ext[DATA_WIDTH-1:0];
        alu_c   = shl_ext[DATA_WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_ext[DATA_WIDTH:1];
        alu_c   = shr_ext[0];
      end
      default: ;
    endcase
    alu_flags = {(alu_res == '0), alu_v, alu_res[DATA_WIDTH-1], alu_c};

    case (op)
      OP_CMP, OP_LD, OP_ST: ;
      OP_MOV: begin
        wr_en  = 1'b1;
        wr_val = ra_val;
      end
      OP_MOVL: begin
        wr_en  = 1'b1;
        wr_val = rd_val;
        wr_val[7:0] = imm8;
      end
      OP_MOVH: begin
        wr_en  = 1'b1;
        wr_val = rd_val;
        wr_val[15:8] = imm8;
      end
      OP_SYS: begin
        wr_en  = (imm8 == 8'd0);
        wr_val = {{(DATA_WIDTH-4){1'b0}}, flags};
      end
      default: begin
        wr_en  = 1'b1;
        wr_val = alu_res;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid && cond_pass && is_mem) state_next = MEM;
      end
      MEM: if (mem_ack) state_next = IDLE;
    endcase
  end

  // Execute / memory-completion stage boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      flags     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retired   <= 1'b0;
    end else begin
      retired <= 1'b0;
      if (accept) begin
        if (!cond_pass || !is_mem) retired <= 1'b1;
        if (exec) begin
          if (flag_en) flags <= alu_flags;
          if (wr_en && (int'(rd) < NUM_REGS)) regs[rd] <= wr_val;
          if (is_mem) begin
            mem_req   <= 1'b1;
            mem_we    <= (op == OP_ST);
            mem_addr  <= ADDRESS_WIDTH'(ra_val);
            mem_wdata <= rd_val;
          end
        end
      end else if (state == MEM && mem_ack) begin
        mem_req <= 1'b0;
        retired <= 1'b1;
        if (!mem_we && (int'(ld_rd) < NUM_REGS)) regs[ld_rd] <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (exec && is_mem) ld_rd <= rd;
  end

`ifdef CORE_BUFFER_SWAP_EN
  logic swap_do;
  assign swap_do = exec && (op == OP_SYS) && (imm8 == 8'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_sel     <= 1'b0;
      frame_count <= '0;
    end else if (swap_do) begin
      buf_sel     <= !buf_sel;
      frame_count <= frame_count + FRAME_COUNT_WIDTH'(1);
    end
  end
`else
  assign buf_sel     = 1'b0;
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_param_core.sv
// Scoreboard bench for param_core: stimulus pushes expected retirement records,
// a monitor pops them on each retired pulse; a memory responder acks with set delays.
`timescale 1ns/1ps
module tb_param_core;
  localparam int DW = 16, AW = 16, NR = 8, FW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
  logic [3:0]    flags;
  logic          buf_sel;
  logic [FW-1:0] frame_count;
  logic          retired;

  param_core #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR), .FRAME_COUNT_WIDTH(FW)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .flags(flags), .buf_sel(buf_sel),
    .frame_count(frame_count), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    flags;
    logic          bs;
    logic [FW-1:0] fc;
    logic          is_mem;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [31:0]   cyc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]    e_flags = 4'h0;
  logic          e_bs = 1'b0;
  logic [FW-1:0] e_fc = '0;

  int            ack_delay = 1;
  logic [DW-1:0] rdata_val = '0;
  int            cnt = 0;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wdata;
  logic          last_we;
  int            last_cyc = 0;
  logic          rdy_bad = 1'b0, unstable = 1'b0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, cond, rd, ra, rb, input logic [7:0] imm);
    return {4'h0, imm, rb, ra, rd, cond, op};
  endfunction

  task automatic issue(input string nm, input logic [31:0] w, input bit is_mem, input bit we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input int dly, input logic [DW-1:0] rdv);
    exp_t e;
    int   n;
    e.flags = e_flags; e.bs = e_bs; e.fc = e_fc;
    e.is_mem = is_mem; e.we = we; e.addr = addr; e.wdata = wdata; e.cyc = dly;
    instr = w;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: instr_ready never asserted, got 0 expected 1", nm);
      instr_valid = 1'b0;
      return;
    end
    ack_delay = dly;
    rdata_val = rdv;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic alu(input string nm, input logic [3:0] op, cond, rd, ra, rb,
                     input logic [7:0] imm, input logic [3:0] f_after);
    e_flags = f_after;
    issue(nm, enc(op, cond, rd, ra, rb, imm), 1'b0, 1'b0, '0, '0, 0, '0);
  endtask

  task automatic st(input string nm, input logic [3:0] rd, ra, input logic [AW-1:0] addr,
                    input logic [DW-1:0] wdata, input int dly);
    issue(nm, enc(4'd14, 4'd10, rd, ra, 4'd0, 8'd0), 1'b1, 1'b1, addr, wdata, dly, '0);
  endtask

  task automatic ld(input string nm, input logic [3:0] rd, ra, input logic [AW-1:0] addr,
                    input logic [DW-1:0] rdv, input int dly);
    issue(nm, enc(4'd13, 4'd10, rd, ra, 4'd0, 8'd0), 1'b1, 1'b0, addr, '0, dly, rdv);
  endtask

  // Memory responder
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (cnt == 0) begin
          last_addr = mem_addr; last_wdata = mem_wdata; last_we = mem_we;
          rdy_bad = 1'b0; unstable = 1'b0;
        end else if (mem_addr !== last_addr || mem_wdata !== last_wdata || mem_we !== last_we) begin
          unstable = 1'b1;
        end
        if (instr_ready) rdy_bad = 1'b1;
        cnt++;
        if (cnt == ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = rdata_val;
          last_cyc = cnt;
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        mem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (retired === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_retire: got retired=1, expected no pending instruction");
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check({nm, "_flags_buf"}, {51'd0, flags, buf_sel, frame_count}, {51'd0, e.flags, e.bs, e.fc});
          if (e.is_mem) begin
            check({nm, "_we"}, {63'd0, last_we}, {63'd0, e.we});
            check({nm, "_addr"}, {48'd0, last_addr}, {48'd0, e.addr});
            check({nm, "_req_cycles"}, 64'(last_cyc), {32'd0, e.cyc});
            check({nm, "_ready_stable"}, {62'd0, rdy_bad, unstable}, 64'd0);
            if (e.we) check({nm, "_wdata"}, {48'd0, last_wdata}, {48'd0, e.wdata});
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_instr_ready", {63'd0, instr_ready}, 64'd1);
    check("rst_flags", {60'd0, flags}, 64'd0);
    check("rst_buf_sel", {63'd0, buf_sel}, 64'd0);
    check("rst_frame_count", {56'd0, frame_count}, 64'd0);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_retired", {63'd0, retired}, 64'd0);

    for (int i = 0; i < 8; i++) st($sformatf("rst_r%0d", i), 4'(i), 4'd15, 16'h0000, 16'h0000, 1);

    alu("movh_r1", 4'd12, 4'd10, 4'd1, 4'd0, 4'd0, 8'h7F, 4'b0000);
    alu("movl_r1", 4'd11, 4'd10, 4'd1, 4'd0, 4'd0, 8'hFF, 4'b0000);
    alu("movl_r2", 4'd11, 4'd10, 4'd2, 4'd0, 4'd0, 8'h01, 4'b0000);
    alu("movh_r2", 4'd12, 4'd10, 4'd2, 4'd0, 4'd0, 8'h00, 4'b0000);
    alu("add_ovf", 4'd0, 4'd10, 4'd3, 4'd1, 4'd2, 8'h00, 4'b0110);
    st("st_r3_slow", 4'd3, 4'd2, 16'h0001, 16'h8000, 3);
    ld("ld_r5", 4'd5, 4'd2, 16'h0001, 16'h1234, 2);
    st("st_r5", 4'd5, 4'd15, 16'h0000, 16'h1234, 1);

    alu("cmp_eq", 4'd9, 4'd10, 4'd0, 4'd2, 4'd2, 8'h00, 4'b1001);
    alu("add_ne_skip", 4'd0, 4'd1, 4'd4, 4'd2, 4'd2, 8'h00, 4'b1001);
    st("st_r4_skip", 4'd4, 4'd15, 16'h0000, 16'h0000, 1);
    alu("sys_flags_r6", 4'd15, 4'd10, 4'd6, 4'd0, 4'd0, 8'h00, 4'b1001);
    st("st_r6", 4'd6, 4'd15, 16'h0000, 16'h0009, 1);

    alu("sub_borrow", 4'd2, 4'd10, 4'd4, 4'd7, 4'd2, 8'h00, 4'b0010);
    alu("add_lt", 4'd0, 4'd3, 4'd4, 4'd2, 4'd2, 8'h00, 4'b0000);
    st("st_r4_lt", 4'd4, 4'd15, 16'h0000, 16'h0002, 1);

    alu("movl_r7", 4'd11, 4'd10, 4'd7, 4'd0, 4'd0, 8'h04, 4'b0000);
    alu("shl4", 4'd7, 4'd10, 4'd4, 4'd1, 4'd7, 8'h00, 4'b0011);
    st("st_shl", 4'd4, 4'd15, 16'h0000, 16'hFFF0, 1);
    alu("shr4", 4'd8, 4'd10, 4'd4, 4'd1, 4'd7, 8'h00, 4'b0001);
    st("st_shr", 4'd4, 4'd15, 16'h0000, 16'h07FF, 1);
    alu("adc_c1", 4'd1, 4'd10, 4'd4, 4'd2, 4'd2, 8'h00, 4'b0000);
    st("st_adc", 4'd4, 4'd15, 16'h0000, 16'h0003, 1);
    alu("sbc_c0", 4'd3, 4'd10, 4'd4, 4'd2, 4'd0, 8'h00, 4'b1001);
    alu("shl0", 4'd7, 4'd10, 4'd4, 4'd1, 4'd0, 8'h00, 4'b0000);
    st("st_shl0", 4'd4, 4'd15, 16'h0000, 16'h7FFF, 1);

    alu("and_zero", 4'd4, 4'd10, 4'd4, 4'd1, 4'd3, 8'h00, 4'b1000);
    alu("xor_neg", 4'd6, 4'd10, 4'd4, 4'd1, 4'd3, 8'h00, 4'b0010);
    st("st_xor", 4'd4, 4'd15, 16'h0000, 16'hFFFF, 1);
    alu("or_neg", 4'd5, 4'd10, 4'd4, 4'd2, 4'd3, 8'h00, 4'b0010);
    st("st_or", 4'd4, 4'd15, 16'h0000, 16'h8001, 1);

    alu("movl_r9", 4'd11, 4'd10, 4'd9, 4'd0, 4'd0, 8'h55, 4'b0010);
    st("st_r9", 4'd9, 4'd15, 16'h0000, 16'h0000, 1);
    alu("movl_nv", 4'd11, 4'd11, 4'd2, 4'd0, 4'd0, 8'hAA, 4'b0010);
    st("st_r2_nv", 4'd2, 4'd15, 16'h0000, 16'h0001, 1);
    alu("cmp_unsigned", 4'd9, 4'd10, 4'd0, 4'd3, 4'd2, 8'h00, 4'b0101);
    alu("movl_cs", 4'd11, 4'd6, 4'd4, 4'd0, 4'd0, 8'h5A, 4'b0101);
    alu("movh_ge_skip", 4'd12, 4'd4, 4'd4, 4'd0, 4'd0, 8'h11, 4'b0101);
    st("st_r4_cond", 4'd4, 4'd15, 16'h0000, 16'h805A, 1);

    for (int i = 0; i < 256; i++) begin
`ifdef CORE_BUFFER_SWAP_EN
      e_bs = ~e_bs;
      e_fc = e_fc + FW'(1);
`endif
      alu($sformatf("swap%0d", i), 4'd15, 4'd10, 4'd0, 4'd0, 4'd0, 8'h01, e_flags);
    end

    ld("ld_abandon", 4'd5, 4'd2, 16'h0001, 16'hBEEF, 1000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abandon_mem_req", {63'd0, mem_req}, 64'd0);
    check("abandon_no_retire", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
    reset = 1'b0;
    e_flags = 4'h0; e_bs = 1'b0; e_fc = '0;
    check("abandon_instr_ready", {63'd0, instr_ready}, 64'd1);
    st("st_r5_after_reset", 4'd5, 4'd15, 16'h0000, 16'h0000, 1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
